uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rcv.sv | 142 ++++++++++++++
 tb/tb_uart_rcv.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and state type
// Shared by uart_rcv and UART_tx.
//   BAUD_DIV_DEFAULT : clocks per bit (50 MHz clock, 19200 baud)
//   HALF_BAUD        : half-bit offset that centres sampling in each bit
//   uart_state_e     : IDLE / RECEIVE (receiver) state encoding
//   half_baud()      : half-bit offset for any divider value
package uart_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;

    function automatic int half_baud(input int baud_div);
        return baud_div / 2;
    endfunction

    localparam int HALF_BAUD = half_baud(BAUD_DIV_DEFAULT);

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } uart_state_e;

endpackage

// File: rtl/uart_rcv.sv
// rtl/uart_rcv.sv - 8N1 UART receiver with sticky ready flag
// Optional feature macro: UART_RCV_FRM_ERR_EN (stop-bit error flag).
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   RX       in   asynchronous serial line, idle high, 8N1, LSB first
//   clr_rdy  in   consumer acknowledge, clears rdy (and frm_err)
//   rx_data  out  [7:0] last correctly completed byte
//   rdy      out  byte available, held until cleared
//   frm_err  out  stop bit sampled low (only with UART_RCV_FRM_ERR_EN)
module uart_rcv
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
`ifdef UART_RCV_FRM_ERR_EN
    ,
    output logic       frm_err
`endif
);

    localparam int               CNT_W    = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_baud(BAUD_DIV));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       LAST_BIT = 4'd9;

    logic             rx_meta_q;
    logic             rx_sync_q;
    uart_state_e      state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic [8:0]       shift_q;
    logic [8:0]       shift_d;
    logic             armed_q;
    logic [7:0]       rx_data_q;
    logic             rdy_q;
    logic             baud_tick;
    logic             start_ok;
`ifdef UART_RCV_FRM_ERR_EN
    logic             frm_err_q;
`endif

    // Counter expires when it would reach zero, so a reload of BAUD_DIV
    // gives exactly BAUD_DIV clocks between samples.
    assign baud_tick = (baud_cnt_q == CNT_ONE);
    assign shift_d   = {rx_sync_q, shift_q[8:1]};
    // At the stop sample shift_q holds {d7..d0, start}; the start sample
    // was already verified low, so this only guards against a corrupt frame.
    assign start_ok  = ~shift_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            armed_q    <= 1'b1;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
`ifdef UART_RCV_FRM_ERR_EN
            frm_err_q  <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;

            // Completion below is written later, so a set in the same clock wins.
            if (clr_rdy) begin
                rdy_q <= 1'b0;
`ifdef UART_RCV_FRM_ERR_EN
                frm_err_q <= 1'b0;
`endif
            end

            case (state_q)
                IDLE: begin
                    // After a frame whose stop bit was low (break), the line
                    // must return high before another start is accepted.
                    if (rx_sync_q) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q    <= RECEIVE;
                        baud_cnt_q <= CNT_HALF;
                        bit_cnt_q  <= '0;
                        rdy_q      <= 1'b0;
`ifdef UART_RCV_FRM_ERR_EN
                        frm_err_q  <= 1'b0;
`endif
                    end
                end
                RECEIVE: begin
                    if (!baud_tick) begin
                        baud_cnt_q <= baud_cnt_q - CNT_ONE;
                    end else begin
                        baud_cnt_q <= CNT_FULL;
                        if (bit_cnt_q == 4'd0 && rx_sync_q) begin
                            // Start bit high at mid-bit: a glitch, not a frame.
                            state_q <= IDLE;
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == LAST_BIT) begin
                                state_q <= IDLE;
                                armed_q <= rx_sync_q;
`ifdef UART_RCV_FRM_ERR_EN
                                if (rx_sync_q && start_ok) begin
                                    rx_data_q <= shift_q[8:1];
                                    rdy_q     <= 1'b1;
                                end else begin
                                    frm_err_q <= 1'b1;
                                end
`else
                                if (start_ok) begin
                                    rx_data_q <= shift_q[8:1];
                                    rdy_q     <= 1'b1;
                                end
`endif
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
`ifdef UART_RCV_FRM_ERR_EN
    assign frm_err = frm_err_q;
`endif

endmodule

// File: tb/tb_uart_rcv.sv
// tb/tb_uart_rcv.sv - scoreboard testbench for uart_rcv
module tb_uart_rcv;
    import uart_pkg::*;

    localparam int B    = 16;
    localparam int HALF = B / 2;
    localparam int LAT  = 2 + HALF + 9 * B;

    typedef struct {
        logic [7:0] data;
        int         start_cyc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;
`ifdef UART_RCV_FRM_ERR_EN
    logic       frm_err;
`endif

    exp_t       exp_q[$];
    exp_t       got;
    logic [7:0] exp_data;
    logic       rdy_prev;
    int         cyc;
    int         n_checks;
    int         n_err;
    int         lat;

    uart_rcv #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
`ifdef UART_RCV_FRM_ERR_EN
        ,
        .frm_err (frm_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rising rdy must match the oldest expected byte.
    initial rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (rdy === 1'b1 && rdy_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rdy: got rx_data %0h with no byte expected (cycle %0d)", rx_data, cyc);
            end else begin
                got = exp_q.pop_front();
                chk("rx_data", 32'(rx_data), 32'(got.data));
                lat = cyc - got.start_cyc;
                n_checks++;
                if (lat < LAT - 2 || lat > LAT + 2) begin
                    n_err++;
                    $display("FAIL latency: got %0d expected %0d +/-2", lat, LAT);
                end
            end
        end
        rdy_prev = rdy;
    end

    // Caller is at #1 after a rising edge; leaves RX at the stop value.
    task automatic send_byte(input logic [7:0] d, input logic stop, input logic deliver);
        exp_t e;
        e.data      = d;
        e.start_cyc = cyc + 1;
        if (deliver) begin
            exp_q.push_back(e);
            exp_data = d;
        end
        RX = 1'b0;
        for (int i = 0; i < 9; i++) begin
            repeat (B) @(posedge clk);
            #1;
            RX = (i < 8) ? d[i] : stop;
        end
        repeat (B) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr;
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

    initial begin
        exp_t       e;
        logic [7:0] abort_byte;
        n_checks = 0;
        n_err    = 0;
        exp_data = 8'h00;
        rst_n    = 1'b0;
        RX       = 1'b1;
        clr_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
`ifdef UART_RCV_FRM_ERR_EN
        chk("reset_frm_err", 32'(frm_err), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single byte, then acknowledge.
        send_byte(8'hA5, 1'b1, 1'b1);
        chk("a5_rdy_held", 32'(rdy), 32'd1);
        pulse_clr();
        chk("a5_clr_rdy", 32'(rdy), 32'd0);

        // Back-to-back frames without acknowledge.
        send_byte(8'h00, 1'b1, 1'b1);
        chk("b2b_rdy_first", 32'(rdy), 32'd1);
        fork
            send_byte(8'hFF, 1'b1, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #2;
                chk("b2b_rdy_low_in_start", 32'(rdy), 32'd0);
            end
        join
        chk("b2b_rdy_second", 32'(rdy), 32'd1);
        pulse_clr();

        // Short low glitch on the line.
        RX = 1'b0;
        repeat (HALF - 3) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (3 * B) @(posedge clk);
        #1;
        chk("glitch_rdy", 32'(rdy), 32'd0);
        chk("glitch_rx_data", 32'(rx_data), 32'(exp_data));
        chk("glitch_idle", 32'(dut.state_q), 32'(IDLE));

        // Frame 3C with the stop bit forced low.
`ifdef UART_RCV_FRM_ERR_EN
        send_byte(8'h3C, 1'b0, 1'b0);
        RX = 1'b1;
        chk("stop0_frm_err", 32'(frm_err), 32'd1);
        chk("stop0_rdy", 32'(rdy), 32'd0);
        chk("stop0_rx_data", 32'(rx_data), 32'(exp_data));
        pulse_clr();
        chk("stop0_frm_err_clr", 32'(frm_err), 32'd0);
`else
        send_byte(8'h3C, 1'b0, 1'b1);
        RX = 1'b1;
        chk("stop0_rdy", 32'(rdy), 32'd1);
        pulse_clr();
`endif
        repeat (2 * B) @(posedge clk);
        #1;

        // Break: line held low well beyond one frame.
        e.data      = 8'h00;
        e.start_cyc = cyc + 1;
`ifndef UART_RCV_FRM_ERR_EN
        exp_q.push_back(e);
        exp_data = 8'h00;
`endif
        RX = 1'b0;
        repeat (15 * B) @(posedge clk);
        #1;
`ifdef UART_RCV_FRM_ERR_EN
        chk("break_frm_err", 32'(frm_err), 32'd1);
        chk("break_rdy", 32'(rdy), 32'd0);
        chk("break_rx_data", 32'(rx_data), 32'(exp_data));
`else
        chk("break_rdy", 32'(rdy), 32'd1);
`endif
        chk("break_wait_idle", 32'(dut.state_q), 32'(IDLE));
        RX = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        send_byte(8'h81, 1'b1, 1'b1);
`ifdef UART_RCV_FRM_ERR_EN
        chk("rearm_frm_err", 32'(frm_err), 32'd0);
`endif
        chk("rearm_rdy", 32'(rdy), 32'd1);
        pulse_clr();
        repeat (B) @(posedge clk);
        #1;

        // clr_rdy coinciding with the completion edge.
        fork
            send_byte(8'h96, 1'b1, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1;
                clr_rdy = 1'b1;
                @(posedge clk);
                #1;
                clr_rdy = 1'b0;
                chk("clr_at_completion_rdy", 32'(rdy), 32'd1);
            end
        join

        // Reset in the middle of data bit 4, then a fresh frame.
        abort_byte = 8'h5A;
        RX = 1'b0;
        repeat (B) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            RX = abort_byte[i];
            repeat (B) @(posedge clk);
            #1;
        end
        RX = abort_byte[4];
        repeat (HALF) @(posedge clk);
        #1;
        rst_n = 1'b0;
        RX    = 1'b1;
        #1;
        chk("midreset_rdy", 32'(rdy), 32'd0);
        chk("midreset_rx_data", 32'(rx_data), 32'h00);
        exp_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * B) @(posedge clk);
        #1;
        chk("midreset_idle", 32'(dut.state_q), 32'(IDLE));
        send_byte(8'h5A, 1'b1, 1'b1);
        chk("post_reset_rdy", 32'(rdy), 32'd1);

        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
